// File: rtl/ast_pkg.sv
// AST shared types: differential alert request/response bundles, channel indices,
// and the per-channel alert source state encoding.
package ast_pkg;

  localparam int unsigned NumAlerts = 11;

  // Alert channel indices
  localparam int unsigned AsSel   = 0;
  localparam int unsigned CgSel   = 1;
  localparam int unsigned GdSel   = 2;
  localparam int unsigned TsHiSel = 3;
  localparam int unsigned TsLoSel = 4;
  localparam int unsigned FlaSel  = 5;
  localparam int unsigned OtpSel  = 6;
  localparam int unsigned Ot0Sel  = 7;
  localparam int unsigned Ot1Sel  = 8;
  localparam int unsigned Ot2Sel  = 9;
  localparam int unsigned Ot3Sel  = 10;

  typedef struct packed {
    logic p;
    logic n;
  } ast_dif_t;

  typedef struct packed {
    ast_dif_t [NumAlerts-1:0] alerts;
  } ast_alert_req_t;

  typedef struct packed {
    ast_dif_t [NumAlerts-1:0] alerts_ack;
    ast_dif_t [NumAlerts-1:0] alerts_trig;
  } ast_alert_rsp_t;

  typedef enum logic [1:0] {
    Idle    = 2'b00,
    Assert  = 2'b01,
    Release = 2'b10,
    HoldOff = 2'b11
  } ast_alert_src_state_e;

endpackage

// File: rtl/ast_alert_chan.sv
// One alert channel: request/ack handshake FSM with hold-off and re-arm, plus
// ack-skew and trigger-encoding integrity checks.
module ast_alert_chan
  import ast_pkg::*;
#(
  parameter int unsigned HoldOffCycles = 4,
  parameter int unsigned SkewMaxCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic evt,
  input  logic ack_p,
  input  logic ack_n,
  input  logic trig_p,
  input  logic trig_n,
  output logic alert_p,
  output logic alert_n,
  output logic pending,
  output logic integ_err
);

  localparam int unsigned CntW = (HoldOffCycles > 1) ? $clog2(HoldOffCycles) : 1;
  localparam int unsigned SkW  = $clog2(SkewMaxCycles + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(HoldOffCycles - 1);
  localparam logic [SkW-1:0]  SkMax   = SkW'(SkewMaxCycles);
  localparam logic [SkW-1:0]  SkLast  = SkW'(SkewMaxCycles - 1);

  ast_alert_src_state_e state_q;
  logic [CntW-1:0]      cnt_q;
  logic [SkW-1:0]       skew_q;
  logic                 rearm_q, trig_bad_q, err_q;

  // Any active trigger leg requests an alert, so a corrupted trigger still fires.
  logic trig_act, trig_bad, req_in;
  logic ack_full, ack_none, ack_skew;
  assign trig_act = trig_p | ~trig_n;
  assign trig_bad = (trig_p == trig_n);
  assign req_in   = evt | trig_act;
  assign ack_full = ack_p & ~ack_n;
  assign ack_none = ~ack_p & ack_n;
  assign ack_skew = ~ack_full & ~ack_none;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      cnt_q      <= '0;
      rearm_q    <= 1'b0;
      skew_q     <= '0;
      trig_bad_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        Idle:    if (req_in) state_q <= Assert;
        Assert:  if (ack_full) state_q <= Release;
        Release: begin
          if (req_in) rearm_q <= 1'b1;
          if (ack_none) begin
            state_q <= HoldOff;
            cnt_q   <= CntInit;
          end
        end
        HoldOff: begin
          if (cnt_q == '0) begin
            state_q <= (rearm_q | req_in) ? Assert : Idle;
            rearm_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
            if (req_in) rearm_q <= 1'b1;
          end
        end
        default: state_q <= Idle;
      endcase

      if (!ack_skew)          skew_q <= '0;
      else if (skew_q != SkMax) skew_q <= skew_q + SkW'(1);

      // Skew threshold and trigger-encoding edge share one pulse.
      trig_bad_q <= trig_bad;
      err_q      <= (ack_skew && skew_q == SkLast) | (trig_bad & ~trig_bad_q);
    end
  end

  assign alert_p   = (state_q == Assert);
  assign alert_n   = ~alert_p;
  assign pending   = (state_q == Assert) | (state_q == Release) | rearm_q;
  assign integ_err = err_q;

endmodule

// File: rtl/ast_alert_src.sv
// Sensor-side alert source: NumAlerts independent channels driving the
// differential alert request bundle and consuming the ack/trigger bundle.
module ast_alert_src #(
  parameter int unsigned NumAlerts     = ast_pkg::NumAlerts,
  parameter int unsigned HoldOffCycles = 4,
  parameter int unsigned SkewMaxCycles = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumAlerts-1:0]       event_i,
  input  ast_pkg::ast_alert_rsp_t    alert_rsp_i,
  output ast_pkg::ast_alert_req_t    alert_req_o,
  output logic [NumAlerts-1:0]       pending_o,
  output logic [NumAlerts-1:0]       integ_err_o
);

  logic [NumAlerts-1:0] alert_p, alert_n;

  for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
    ast_alert_chan #(
      .HoldOffCycles(HoldOffCycles),
      .SkewMaxCycles(SkewMaxCycles)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .evt      (event_i[i]),
      .ack_p    (alert_rsp_i.alerts_ack[i].p),
      .ack_n    (alert_rsp_i.alerts_ack[i].n),
      .trig_p   (alert_rsp_i.alerts_trig[i].p),
      .trig_n   (alert_rsp_i.alerts_trig[i].n),
      .alert_p  (alert_p[i]),
      .alert_n  (alert_n[i]),
      .pending  (pending_o[i]),
      .integ_err(integ_err_o[i])
    );
  end

  always_comb begin
    alert_req_o = '0;
    for (int i = 0; i < NumAlerts; i++) begin
      alert_req_o.alerts[i].p = alert_p[i];
      alert_req_o.alerts[i].n = alert_n[i];
    end
  end

endmodule

// File: tb/tb_ast_alert_src.sv
// Bench for ast_alert_src: directed vector table, hand sequences and a
// randomized run against a timestamp-based reference model.
module tb_ast_alert_src;
  import ast_pkg::*;

  localparam int N  = NumAlerts;
  localparam int H  = 4;
  localparam int SK = 2;
  localparam bit [1:0] AN = 2'b01, AF = 2'b10, AS = 2'b11;
  localparam bit [1:0] TO = 2'b01, TT = 2'b10, TB = 2'b00;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   event_i;
  ast_alert_rsp_t rsp;
  ast_alert_req_t req;
  logic [N-1:0]   pending, integ;

  ast_alert_src #(.NumAlerts(N), .HoldOffCycles(H), .SkewMaxCycles(SK)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .event_i(event_i), .alert_rsp_i(rsp),
    .alert_req_o(req), .pending_o(pending), .integ_err_o(integ)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    event_i = '0;
    for (int i = 0; i < N; i++) begin
      rsp.alerts_ack[i]  = ast_dif_t'(AN);
      rsp.alerts_trig[i] = ast_dif_t'(TO);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_alert[N], m_wait[N], m_rearm[N], m_tbp[N], m_err[N];
  int m_qend[N], m_run[N];
  int cyc;

  function automatic void model_init();
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_alert[i] = 0; m_wait[i] = 0; m_rearm[i] = 0; m_tbp[i] = 0;
      m_err[i] = 0; m_qend[i] = -1; m_run[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      bit tp, tn, ap, an, rq, full, none, skew, tb;
      int old;
      tp = rsp.alerts_trig[i].p; tn = rsp.alerts_trig[i].n;
      ap = rsp.alerts_ack[i].p;  an = rsp.alerts_ack[i].n;
      rq   = event_i[i] | tp | ~tn;
      tb   = (tp == tn);
      full = ap && !an;
      none = !ap && an;
      skew = !full && !none;
      if (m_alert[i]) begin
        if (full) begin m_alert[i] = 0; m_wait[i] = 1; end
      end else if (m_wait[i]) begin
        if (rq) m_rearm[i] = 1;
        if (none) begin m_wait[i] = 0; m_qend[i] = cyc + H; end
      end else if (m_qend[i] >= 0) begin
        if (rq) m_rearm[i] = 1;
        if (cyc == m_qend[i]) begin
          m_alert[i] = m_rearm[i];
          m_rearm[i] = 0;
          m_qend[i]  = -1;
        end
      end else if (rq) m_alert[i] = 1;
      old = m_run[i];
      m_run[i] = skew ? ((old < SK) ? old + 1 : SK) : 0;
      m_err[i] = (skew && m_run[i] == SK && old < SK) || (tb && !m_tbp[i]);
      m_tbp[i] = tb;
    end
    cyc++;
  endfunction

  task automatic reset_dut();
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive_idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_init();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int     ch;
    bit     evt;
    bit [1:0] ack, trig;
    bit     ep, epend, eerr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int ch, bit e, bit [1:0] a, bit [1:0] t, bit p, bit pd, bit er);
    vec_t v;
    v = '{ch, e, a, t, p, pd, er};
    tbl.push_back(v);
  endfunction

  initial begin
    int rises[$];
    bit pprev, pcur, others_ok, seen;

    // channel 0: basic handshake and hold-off back to idle
    add(0,0,AN,TO,0,0,0); add(0,1,AN,TO,1,1,0); add(0,0,AN,TO,1,1,0); add(0,0,AN,TO,1,1,0);
    add(0,0,AF,TO,0,1,0); add(0,0,AF,TO,0,1,0); add(0,0,AN,TO,0,0,0); add(0,0,AN,TO,0,0,0);
    add(0,0,AN,TO,0,0,0); add(0,0,AN,TO,0,0,0); add(0,0,AN,TO,0,0,0);
    // channel 5: re-arm in hold-off, absorb in Assert, ack+req drops request
    add(5,1,AN,TO,1,1,0); add(5,0,AF,TO,0,1,0); add(5,0,AN,TO,0,0,0); add(5,1,AN,TO,0,1,0);
    add(5,0,AN,TO,0,1,0); add(5,0,AN,TO,0,1,0); add(5,0,AN,TO,1,1,0); add(5,1,AN,TO,1,1,0);
    add(5,1,AF,TO,0,1,0); add(5,0,AN,TO,0,0,0); add(5,0,AN,TO,0,0,0); add(5,0,AN,TO,0,0,0);
    add(5,0,AN,TO,0,0,0); add(5,0,AN,TO,0,0,0); add(5,0,AF,TO,0,0,0);
    // channel 2: skewed ack in Assert
    add(2,1,AN,TO,1,1,0); add(2,0,AS,TO,1,1,0); add(2,0,AS,TO,1,1,1); add(2,0,AS,TO,1,1,0);
    add(2,0,AF,TO,0,1,0); add(2,0,AN,TO,0,0,0); add(2,0,AN,TO,0,0,0); add(2,0,AN,TO,0,0,0);
    add(2,0,AN,TO,0,0,0); add(2,0,AN,TO,0,0,0);
    // channel 7: valid trigger, then bad encoding still alerts
    add(7,0,AN,TT,1,1,0); add(7,0,AF,TO,0,1,0); add(7,0,AN,TO,0,0,0); add(7,0,AN,TO,0,0,0);
    add(7,0,AN,TO,0,0,0); add(7,0,AN,TO,0,0,0); add(7,0,AN,TO,0,0,0);
    add(7,0,AN,TB,1,1,1); add(7,0,AN,TB,1,1,0); add(7,0,AF,TO,0,1,0); add(7,0,AN,TO,0,0,0);
    add(7,0,AN,TO,0,0,0); add(7,0,AN,TO,0,0,0); add(7,0,AN,TO,0,0,0); add(7,0,AN,TO,0,0,0);

    rst_ni = 1'b0;
    drive_idle();
    #12;
    chk("reset_p",    req.alerts[0].p ? 1 : 0, 0);
    for (int i = 0; i < N; i++) begin
      if (req.alerts[i].p !== 1'b0 || req.alerts[i].n !== 1'b1) chk("reset_pn", i, 32'hffff);
    end
    chk("reset_pending", pending, 0);
    chk("reset_integ",   integ, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk_i);
      drive_idle();
      event_i[tbl[k].ch]          = tbl[k].evt;
      rsp.alerts_ack[tbl[k].ch]  = ast_dif_t'(tbl[k].ack);
      rsp.alerts_trig[tbl[k].ch] = ast_dif_t'(tbl[k].trig);
      @(posedge clk_i); #1;
      chk($sformatf("row%0d_p", k),    req.alerts[tbl[k].ch].p, tbl[k].ep);
      chk($sformatf("row%0d_n", k),    req.alerts[tbl[k].ch].n, !tbl[k].ep);
      chk($sformatf("row%0d_pend", k), pending[tbl[k].ch],     tbl[k].epend);
      chk($sformatf("row%0d_err", k),  integ[tbl[k].ch],       tbl[k].eerr);
    end

    // level-held event on channel 3 with a 1-cycle responder
    pprev = 0; others_ok = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      drive_idle();
      event_i[3] = 1'b1;
      pcur = req.alerts[3].p;
      rsp.alerts_ack[3] = (pcur && pprev) ? ast_dif_t'(AF) : ast_dif_t'(AN);
      pprev = pcur;
      @(posedge clk_i); #1;
      if (req.alerts[3].p && !pcur) rises.push_back(c);
      for (int i = 0; i < N; i++)
        if (i != 3 && (req.alerts[i].p !== 1'b0 || req.alerts[i].n !== 1'b1)) others_ok = 0;
    end
    chk("ch3_rise_count_ge4", rises.size() >= 4, 1);
    for (int k = 1; k < rises.size(); k++)
      chk($sformatf("ch3_period%0d", k), rises[k] - rises[k-1], 7);
    chk("ch3_others_quiet", others_ok, 1);

    // asynchronous reset while channel 1 is in Assert
    reset_dut();
    @(negedge clk_i); event_i[1] = 1'b1;
    @(negedge clk_i); event_i[1] = 1'b0;
    chk("rst_pre_p1", req.alerts[1].p, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_p1",   req.alerts[1].p, 0);
    chk("rst_async_n1",   req.alerts[1].n, 1);
    chk("rst_async_pend", pending, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      if (req.alerts[1].p || pending[1]) seen = 1;
    end
    chk("rst_no_replay", seen, 0);

    // randomized run against the reference model
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] ep, en, epd, eer, ap, an;
      @(negedge clk_i);
      for (int i = 0; i < N; i++) begin
        int r;
        event_i[i] = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 9);
        rsp.alerts_ack[i] = (r < 4) ? ast_dif_t'(AN) : (r < 7) ? ast_dif_t'(AF) :
                            (r < 9) ? ast_dif_t'(AS) : ast_dif_t'(2'b00);
        rsp.alerts_trig[i] = ($urandom_range(0, 19) == 0) ? ast_dif_t'($urandom_range(0, 3))
                                                          : ast_dif_t'(TO);
      end
      @(posedge clk_i);
      model_step();
      #1;
      for (int i = 0; i < N; i++) begin
        ep[i] = m_alert[i]; en[i] = !m_alert[i];
        epd[i] = m_alert[i] | m_wait[i] | m_rearm[i]; eer[i] = m_err[i];
        ap[i] = req.alerts[i].p; an[i] = req.alerts[i].n;
      end
      chk($sformatf("rnd%0d_p", c),    ap, ep);
      chk($sformatf("rnd%0d_n", c),    an, en);
      chk($sformatf("rnd%0d_pend", c), pending, epd);
      chk($sformatf("rnd%0d_err", c),  integ, eer);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ast_alert_src.md
Name: ast_alert_src

Overview:
- Sensor-side alert source for the AST alert interface: the transmitting end of the differential alert request/ack channel that sensor_ctrl receives.
- Converts per-sensor event pulses and levels, plus software test triggers, into differential alert requests (p/n).
- Holds each request until a differential ack returns, then releases it and applies a hold-off period.
- Sits in the AST/sensor domain. One instance drives ast_alert_req_t into sensor_ctrl and consumes its ast_alert_rsp_t.

Parameters:
- NumAlerts, ast_pkg::NumAlerts: number of alert channels (11).
- HoldOffCycles, 4: cycles a channel stays quiet after ack release before re-asserting; must be >= 1.
- SkewMaxCycles, 2: cycles an ack leg pair may disagree before an integrity error is flagged; must be >= 1.

Ports:
- clk_i  in  1  clock. One clock; all logic is synchronous to it.
- rst_ni  in  1  reset, asynchronous and active-low.
- event_i  in  NumAlerts  sensor event per channel (level or pulse; synchronous).
- alert_rsp_i  in  ast_alert_rsp_t  per-channel differential ack (alerts_ack[i].p/.n) and test trigger (alerts_trig[i].p/.n).
- alert_req_o  out  ast_alert_req_t  per-channel differential alert (alerts[i].p/.n).
- pending_o  out  NumAlerts  channel has an unacknowledged or re-armed alert.
- integ_err_o  out  NumAlerts  one-cycle pulse on an ack-skew or trigger-encoding error.

Behaviour:
- Reset values: alerts[i].p=0, alerts[i].n=1, pending_o=0, integ_err_o=0. All channel FSMs in Idle, counters 0.
- Decoding per channel:
  - req_in = event_i[i] | trig_act.
  - trig_act = alerts_trig.p | ~alerts_trig.n. This is fail-safe: any leg active counts as a trigger.
  - trig_bad = (alerts_trig.p == alerts_trig.n).
  - ack_full = ack.p & ~ack.n.
  - ack_none = ~ack.p & ack.n.
  - ack_skew = ~ack_full & ~ack_none.
- Outputs are registered: p = (state==Assert), n = ~p, both legs from the same flop stage, never split across cycles.
- Per-channel FSM:
  - Idle: req_in -> Assert. The request is visible on p/n the following cycle (latency 1).
  - Assert: ack_full -> Release. req_in during Assert is absorbed (no re-arm).
  - Release: p/n deasserted. Wait for ack_none, then -> HoldOff with cnt=HoldOffCycles-1. req_in here sets rearm.
  - HoldOff: cnt decrements each cycle. req_in sets rearm. At cnt==0: rearm -> Assert (rearm cleared), else -> Idle.
- A level-held event_i therefore produces a repeating alert with period >= 3 + HoldOffCycles cycles, given a 1-cycle responder.
- pending_o[i] = (state==Assert) | (state==Release) | rearm.
- Skew checker:
  - skew_cnt increments while ack_skew holds, clears otherwise, and saturates at SkewMaxCycles.
  - integ_err_o pulses once when skew_cnt reaches SkewMaxCycles.
  - A skewed ack is never accepted as ack_full.
- trig_bad raises an integ_err_o pulse on its rising edge (registered, 1-cycle latency).
- If trig_bad and ack_skew errors occur in the same cycle, they produce a single pulse.
- Simultaneous events:
  - ack_full and req_in in the same cycle while in Assert: take Release; the request is dropped, because it is covered by the in-flight alert.
  - ack_full while in Idle/Release/HoldOff: ignored.
  - ack_none while in Assert: stay in Assert.
- Reset asserted mid-operation returns all state to the reset values immediately (async). No replay after reset.
- Channels are fully independent; there is no cross-channel arbitration.

Decomposition:
- ast_pkg already holds ast_alert_req_t, ast_alert_rsp_t, NumAlerts and the *Sel indices. Add the channel state enum ast_alert_src_state_e {Idle, Assert, Release, HoldOff} there, with explicit encodings.
- Sub-module ast_alert_chan: one FSM, hold-off counter, skew counter, rearm flag. The top ast_alert_src generates NumAlerts instances and packs/unpacks the p/n structs.

Test Plan:
- Reset, then a 1-cycle event_i[0] pulse at cycle 10 -> alerts[0].p=1/n=0 at cycle 11, pending_o[0]=1. Hold ack_full from cycle 14 to 15 -> p=0 at cycle 15. After ack_none, Idle after 4 hold-off cycles; pending_o[0]=0.
- Hold event_i[3]=1 with a responder that acks 1 cycle after p rises and releases 1 cycle later -> repeated alerts on channel 3 with period 7 cycles; other channels stay p=0/n=1.
- event_i[5] pulse during HoldOff -> re-asserts exactly when the counter hits 0. Same pulse during Assert -> no extra alert.
- Drive ack[2].p=1, n=1 for 3 cycles while in Assert -> one integ_err_o[2] pulse after 2 cycles; the channel stays in Assert. A correct ack_full afterwards moves it to Release.
- alerts_trig[7] p=1/n=0 -> alert on channel 7. Then p=0/n=0 -> integ_err_o[7] pulse and an alert is still generated (fail-safe).
- Assert rst_ni while channel 1 is in Assert -> p=0/n=1 and pending_o=0 asynchronously. No alert after release of reset unless event_i[1] is high.
